// File: rtl/alu_pkg.sv
// Shared definitions for the alu and the two-requester alu arbiter:
// opcode encodings and the arbiter FSM states.
package alu_pkg;

    localparam logic [2:0] OP_A     = 3'b000;
    localparam logic [2:0] OP_B     = 3'b001;
    localparam logic [2:0] OP_NEG_A = 3'b010;
    localparam logic [2:0] OP_NEG_B = 3'b011;
    localparam logic [2:0] OP_LT    = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_ADD   = 3'b110;
    localparam logic [2:0] OP_SUB   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational alu selected by {f,x,n}; two's complement arithmetic
// truncated to WIDTH, signed compare for A<B.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             f,
    input  logic             x,
    input  logic             n,
    output logic [WIDTH-1:0] num_or_less_than
);

    logic w_lt;

    assign w_lt = $signed(input1) < $signed(input2);

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        num_or_less_than = '0;
        case ({f, x, n})
            OP_A:     num_or_less_than = input1;
            OP_B:     num_or_less_than = input2;
            OP_NEG_A: num_or_less_than = -input1;
            OP_NEG_B: num_or_less_than = -input2;
            OP_LT:    num_or_less_than = {{(WIDTH-1){1'b0}}, w_lt};
            OP_XNOR:  num_or_less_than = ~(input1 ^ input2);
            OP_ADD:   num_or_less_than = input1 + input2;
            OP_SUB:   num_or_less_than = input1 - input2;
            default:  num_or_less_than = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one alu between two requesters: accept one op in IDLE,
// evaluate it from latched operands in EXEC, hold the tagged result in RESP.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_rr_ptr;
    logic [2:0]       r_op_q;
    logic [WIDTH-1:0] r_a_q;
    logic [WIDTH-1:0] r_b_q;
    logic             r_id_q;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;
    logic [CNT_W-1:0] r_ops_done;

    logic             w_any_valid;
    logic             w_grant;
    logic             w_req0_ready;
    logic             w_req1_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_alu_y;

    // With both valid the pointer decides; otherwise the lone valid requester wins.
    assign w_any_valid = req0_valid | req1_valid;
    assign w_grant     = (req0_valid & req1_valid) ? r_rr_ptr : req1_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_req0_ready = 1'b0;
        w_req1_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!reset && w_any_valid) begin
                    w_req0_ready = ~w_grant;
                    w_req1_ready = w_grant;
                    w_state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: w_state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept = w_req0_ready | w_req1_ready;

    // Only the latched operands feed the alu, so requester inputs may move freely after accept.
    alu #(.WIDTH(WIDTH)) u_alu (
        .input1           (r_a_q),
        .input2           (r_b_q),
        .f                (r_op_q[2]),
        .x                (r_op_q[1]),
        .n                (r_op_q[0]),
        .num_or_less_than (w_alu_y)
    );

    // NOTE: the operand registers are reset too, so a dropped op leaves no stale
    // state behind; nothing here is a memory array, so a full reset is cheap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr    <= 1'b0;
            r_op_q      <= '0;
            r_a_q       <= '0;
            r_b_q       <= '0;
            r_id_q      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_ops_done  <= '0;
        end else begin
            if (w_accept) begin
                r_op_q <= w_grant ? req1_op : req0_op;
                r_a_q  <= w_grant ? req1_a  : req0_a;
                r_b_q  <= w_grant ? req1_b  : req0_b;
                r_id_q <= w_grant;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_data  <= w_alu_y;
                r_rsp_id    <= r_id_q;
                r_rsp_valid <= 1'b1;
            end else if (r_state == ST_RESP && rsp_ready) begin
                r_rsp_valid <= 1'b0;
                r_ops_done  <= r_ops_done + 1'b1;
                r_rr_ptr    <= ~r_id_q;
            end
        end
    end

    assign req0_ready = w_req0_ready;
    assign req1_ready = w_req1_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign busy       = (r_state != ST_IDLE);
    assign ops_done   = r_ops_done;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, single op, contention, fairness,
// backpressure, reset mid-op, input change after accept and counter wrap.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 6;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [2:0]       req0_op, req1_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic             rsp_valid, rsp_ready, rsp_id, busy;
    logic [WIDTH-1:0] rsp_data;
    logic [CNT_W-1:0] ops_done;

    int n_vec = 0;
    int n_err = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .ops_done   (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no end, expected finish");
        $fatal(1, "watchdog");
    end

    // Called on a negedge; returns on a negedge with the reset pulse applied.
    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge just after the handshake edge.
    task automatic issue(input bit port, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         output bit ok);
        if (port) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if ((port ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        if (port) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
    endtask

    // Waits for rsp_valid, captures the response, and returns after its handshake.
    task automatic collect(output bit ok, output logic id, output logic [WIDTH-1:0] data);
        rsp_ready = 1'b1;
        ok = 1'b0;
        id = 1'b0;
        data = '0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid === 1'b1) begin
                id = rsp_id;
                data = rsp_data;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_req0_ready: observed %0b, expected 0", req0_ready); end
        n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_req1_ready: observed %0b, expected 0", req1_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: observed %0b, expected 0", rsp_valid); end
        n_vec++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL reset_rsp_id: observed %0b, expected 0", rsp_id); end
        n_vec++; if (rsp_data !== 6'd0) begin n_err++; $display("FAIL reset_rsp_data: observed %0h, expected 0", rsp_data); end
        n_vec++; if (ops_done !== 8'd0) begin n_err++; $display("FAIL reset_ops_done: observed %0d, expected 0", ops_done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: observed %0b, expected 0", busy); end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_op();
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 6'b000001; req0_b = 6'b000001;
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL single_req0_ready: observed %0b, expected 1", req0_ready); end
        n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL single_req1_ready: observed %0b, expected 0", req1_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy_exec: observed %0b, expected 1", busy); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_valid_early: observed %0b, expected 0", rsp_valid); end
        @(negedge clk);
        req0_valid = 1'b1;
        #1;
        n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid: observed %0b, expected 1", rsp_valid); end
        n_vec++; if (rsp_id !== 1'b0) begin n_err++; $display("FAIL single_rsp_id: observed %0b, expected 0", rsp_id); end
        n_vec++; if (rsp_data !== 6'b000010) begin n_err++; $display("FAIL single_rsp_data: observed %b, expected 000010", rsp_data); end
        n_vec++; if (req0_ready !== 1'b0) begin n_err++; $display("FAIL single_ready_in_resp: observed %0b, expected 0", req0_ready); end
        req0_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_cleared: observed %0b, expected 0", rsp_valid); end
        n_vec++; if (ops_done !== 8'd1) begin n_err++; $display("FAIL single_ops_done: observed %0d, expected 1", ops_done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_idle: observed %0b, expected 0", busy); end
    endtask

    task automatic test_contention();
        bit ok;
        logic id;
        logic [WIDTH-1:0] data;
        apply_reset();
        req0_valid = 1'b1; req0_op = OP_SUB;   req0_a = 6'b000111; req0_b = 6'b000011;
        req1_valid = 1'b1; req1_op = OP_NEG_A; req1_a = 6'b001100; req1_b = 6'b000000;
        #1;
        n_vec++; if (req0_ready !== 1'b1) begin n_err++; $display("FAIL cont_req0_ready: observed %0b, expected 1", req0_ready); end
        n_vec++; if (req1_ready !== 1'b0) begin n_err++; $display("FAIL cont_req1_ready: observed %0b, expected 0", req1_ready); end
        @(negedge clk);
        req0_valid = 1'b0;
        collect(ok, id, data);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL cont_rsp0_timeout: observed %0b, expected 1", ok); end
        n_vec++; if (id !== 1'b0) begin n_err++; $display("FAIL cont_rsp0_id: observed %0b, expected 0", id); end
        n_vec++; if (data !== 6'b000100) begin n_err++; $display("FAIL cont_rsp0_data: observed %b, expected 000100", data); end
        issue(1'b1, OP_NEG_A, 6'b001100, 6'b000000, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL cont_req1_accept: observed %0b, expected 1", ok); end
        collect(ok, id, data);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL cont_rsp1_timeout: observed %0b, expected 1", ok); end
        n_vec++; if (id !== 1'b1) begin n_err++; $display("FAIL cont_rsp1_id: observed %0b, expected 1", id); end
        n_vec++; if (data !== 6'b110100) begin n_err++; $display("FAIL cont_rsp1_data: observed %b, expected 110100", data); end
        n_vec++; if (ops_done !== 8'd2) begin n_err++; $display("FAIL cont_ops_done: observed %0d, expected 2", ops_done); end
    endtask

    task automatic test_fairness();
        bit got;
        logic exp_id;
        logic [WIDTH-1:0] exp_data;
        apply_reset();
        req0_valid = 1'b1; req0_op = OP_A; req0_a = 6'd5; req0_b = 6'd0;
        req1_valid = 1'b1; req1_op = OP_B; req1_a = 6'd0; req1_b = 6'd9;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_id = (i % 2 == 1);
            exp_data = exp_id ? 6'd9 : 6'd5;
            got = 1'b0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (rsp_valid === 1'b1) begin
                    got = 1'b1;
                    break;
                end
            end
            if (i == 5) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL fair_rsp_timeout[%0d]: observed %0b, expected 1", i, got); end
            n_vec++; if (rsp_id !== exp_id) begin n_err++; $display("FAIL fair_grant_id[%0d]: observed %0b, expected %0b", i, rsp_id, exp_id); end
            n_vec++; if (rsp_data !== exp_data) begin n_err++; $display("FAIL fair_data[%0d]: observed %0d, expected %0d", i, rsp_data, exp_data); end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        n_vec++; if (ops_done !== 8'd6) begin n_err++; $display("FAIL fair_ops_done: observed %0d, expected 6", ops_done); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL fair_busy: observed %0b, expected 0", busy); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit got;
        issue(1'b1, OP_LT, 6'b000011, 6'b000110, ok);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL bp_accept: observed %0b, expected 1", ok); end
        rsp_ready = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL bp_rsp_timeout: observed %0b, expected 1", got); end
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_rsp_valid[%0d]: observed %0b, expected 1", k, rsp_valid); end
            n_vec++; if (rsp_data !== 6'b000001) begin n_err++; $display("FAIL bp_rsp_data[%0d]: observed %b, expected 000001", k, rsp_data); end
            n_vec++; if (rsp_id !== 1'b1) begin n_err++; $display("FAIL bp_rsp_id[%0d]: observed %0b, expected 1", k, rsp_id); end
            n_vec++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL bp_ready[%0d]: observed %b, expected 00", k, {req0_ready, req1_ready}); end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_complete: observed %0b, expected 0", rsp_valid); end
        n_vec++; if (ops_done !== 8'd7) begin n_err++; $display("FAIL bp_ops_done: observed %0d, expected 7", ops_done); end
    endtask

    task automatic test_reset_exec();
        bit ok;
        logic id;
        logic [WIDTH-1:0] data;
        issue(1'b0, OP_XNOR, 6'b101010, 6'b110011, ok);
        collect(ok, id, data);
        n_vec++; if (data !== 6'b100110) begin n_err++; $display("FAIL rexec_xnor_data: observed %b, expected 100110", data); end
        issue(1'b0, OP_B, 6'b000000, 6'b000011, ok);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rexec_in_exec: observed %0b, expected 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rexec_busy: observed %0b, expected 0", busy); end
        n_vec++; if (ops_done !== 8'd0) begin n_err++; $display("FAIL rexec_ops_done: observed %0d, expected 0", ops_done); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rexec_no_rsp[%0d]: observed %0b, expected 0", k, rsp_valid); end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 6'b000001; req0_b = 6'b000001;
        req1_valid = 1'b1; req1_op = OP_A;   req1_a = 6'b000011; req1_b = 6'b000000;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL rexec_rr_ptr: observed %b, expected 10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        collect(ok, id, data);
        n_vec++; if ({ok, id, data} !== {1'b1, 1'b0, 6'b000010}) begin n_err++; $display("FAIL rexec_next_op: observed %b, expected 10000010", {ok, id, data}); end
        n_vec++; if (ops_done !== 8'd1) begin n_err++; $display("FAIL rexec_next_ops_done: observed %0d, expected 1", ops_done); end
    endtask

    task automatic test_input_change();
        bit ok;
        logic id;
        logic [WIDTH-1:0] data;
        issue(1'b1, OP_A, 6'b000111, 6'b000000, ok);
        req1_a = 6'b111111;
        req1_op = OP_ADD;
        req1_b = 6'b010101;
        collect(ok, id, data);
        n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL chg_timeout: observed %0b, expected 1", ok); end
        n_vec++; if (id !== 1'b1) begin n_err++; $display("FAIL chg_id: observed %0b, expected 1", id); end
        n_vec++; if (data !== 6'b000111) begin n_err++; $display("FAIL chg_data: observed %b, expected 000111", data); end
    endtask

    task automatic test_wrap();
        bit ok;
        bit all_ok;
        logic id;
        logic [WIDTH-1:0] data;
        apply_reset();
        all_ok = 1'b1;
        for (int i = 0; i < 256; i++) begin
            issue(1'b0, OP_A, 6'(i), 6'd0, ok);
            all_ok = all_ok & ok;
            collect(ok, id, data);
            all_ok = all_ok & ok;
            if (i == 254) begin
                n_vec++; if (ops_done !== 8'd255) begin n_err++; $display("FAIL wrap_max: observed %0d, expected 255", ops_done); end
            end
        end
        n_vec++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL wrap_handshakes: observed %0b, expected 1", all_ok); end
        n_vec++; if (data !== 6'd63) begin n_err++; $display("FAIL wrap_last_data: observed %0d, expected 63", data); end
        n_vec++; if (ops_done !== 8'd0) begin n_err++; $display("FAIL wrap_zero: observed %0d, expected 0", ops_done); end
    endtask

    initial begin
        reset = 1'b1;
        req0_valid = 1'b0; req0_op = 3'b000; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = 3'b000; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single_op();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_exec();
        test_input_change();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
